// File: rtl/rtable_pkg.sv
// Shared reward-table constants and the lookup pipeline tag type.
package rtable_pkg;

  localparam int unsigned NUM_ACTIONS = 4;
  localparam int unsigned DEPTH       = 256;
  localparam int unsigned ADDR_WIDTH  = 8;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned MAX_REQ     = 8;

  localparam logic [DATA_WIDTH-1:0] DEFAULT_REWARD = 8'hF7;

  // Sized for the largest supported requester count; unused id bits stay zero.
  typedef struct packed {
    logic [MAX_REQ-1:0] id;
    logic               oor;
  } tag_t;

endpackage

// File: rtl/rtable_arbiter_if.sv
// Requester-side and ROM-side signals of the reward-table arbiter.
interface rtable_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned STATE_W    = 6,
  parameter int unsigned ACTION_W   = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);

  logic                         i_hold;
  logic [NUM_REQ-1:0]           i_req;
  logic [NUM_REQ*STATE_W-1:0]   i_state;
  logic [NUM_REQ*ACTION_W-1:0]  i_action;
  logic [NUM_REQ-1:0]           o_gnt;
  logic [ADDR_WIDTH-1:0]        o_rom_addr;
  logic                         o_rom_read;
  logic [DATA_WIDTH-1:0]        i_rom_data;
  logic [NUM_REQ-1:0]           o_rsp_valid;
  logic [DATA_WIDTH-1:0]        o_rsp_data;
  logic                         o_rsp_oor;
  logic                         o_busy;

  modport slave (
    input  i_hold, i_req, i_state, i_action, i_rom_data,
    output o_gnt, o_rom_addr, o_rom_read, o_rsp_valid, o_rsp_data, o_rsp_oor, o_busy
  );

  modport master (
    output i_hold, i_req, i_state, i_action, i_rom_data,
    input  o_gnt, o_rom_addr, o_rom_read, o_rsp_valid, o_rsp_data, o_rsp_oor, o_busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a stored pointer.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic            found;
    logic [PtrW-1:0] j;
    found = 1'b0;
    j     = '0;
    o_gnt = '0;
    ptr_d = ptr_q;
    if (i_en) begin
      for (int unsigned i = 0; i < N; i++) begin
        j = PtrW'((32'(ptr_q) + i) % N);
        if (!found && i_req[j]) begin
          found    = 1'b1;
          o_gnt[j] = 1'b1;
          ptr_d    = (32'(j) == N - 1) ? '0 : j + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rtable_arbiter.sv
// Shares one synchronous reward ROM between NUM_REQ requesters; fixed two-cycle
// grant-to-response latency, one lookup per cycle.
module rtable_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned STATE_W     = 6,
  parameter int unsigned ACTION_W    = 2,
  parameter int unsigned NUM_ACTIONS = rtable_pkg::NUM_ACTIONS,
  parameter int unsigned ADDR_WIDTH  = rtable_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = rtable_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH       = rtable_pkg::DEPTH,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_REWARD = rtable_pkg::DEFAULT_REWARD
) (
  input logic             i_clk,
  input logic             i_rst_n,
  rtable_arbiter_if.slave bus
);

  import rtable_pkg::*;

  localparam int unsigned IDX_W = STATE_W + ACTION_W + 1;

  logic [NUM_REQ-1:0]    gnt;
  logic                  any_gnt;
  logic [STATE_W-1:0]    sel_state;
  logic [ACTION_W-1:0]   sel_action;
  logic [IDX_W-1:0]      idx;
  logic                  oor;
  logic [NUM_REQ-1:0]    rsp_valid;
  tag_t                  tag1_q, tag1_d, tag2_q, tag2_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  rom_read_q, rom_read_d;

  // Gating with reset keeps the combinational grant quiet while in reset.
  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (!bus.i_hold && i_rst_n),
    .i_req   (bus.i_req),
    .o_gnt   (gnt)
  );

  assign any_gnt = |gnt;

  always_comb begin
    sel_state  = '0;
    sel_action = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_state  = sel_state | bus.i_state[k*STATE_W +: STATE_W];
        sel_action = sel_action | bus.i_action[k*ACTION_W +: ACTION_W];
      end
    end
  end

  // Full-width index so that overflow past DEPTH is detected rather than wrapped.
  assign idx = IDX_W'(sel_state) * IDX_W'(NUM_ACTIONS) + IDX_W'(sel_action);
  assign oor = (32'(sel_action) >= NUM_ACTIONS) || (32'(idx) >= DEPTH);

  always_comb begin
    tag1_d                 = '0;
    tag1_d.id[NUM_REQ-1:0] = gnt;
    tag1_d.oor             = any_gnt & oor;
    rom_read_d             = any_gnt & ~oor;
    rom_addr_d             = rom_read_d ? ADDR_WIDTH'(idx) : rom_addr_q;
    tag2_d                 = tag1_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag1_q     <= '0;
      tag2_q     <= '0;
      rom_addr_q <= '0;
      rom_read_q <= 1'b0;
    end else begin
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
      rom_addr_q <= rom_addr_d;
      rom_read_q <= rom_read_d;
    end
  end

  assign rsp_valid       = tag2_q.id[NUM_REQ-1:0];
  assign bus.o_gnt       = gnt;
  assign bus.o_rom_addr  = rom_addr_q;
  assign bus.o_rom_read  = rom_read_q;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_data  = (|rsp_valid) ? (tag2_q.oor ? DEFAULT_REWARD : bus.i_rom_data) : '0;
  assign bus.o_rsp_oor   = (|rsp_valid) & tag2_q.oor;
  assign bus.o_busy      = (|tag1_q.id) | (|tag2_q.id);

endmodule

// File: doc/rtable_arbiter.md
Name: rtable_arbiter

Overview:
- Shares the single synchronous reward-table ROM between NUM_REQ Q-learning update pipelines.
- Each requester presents a (state, action) pair. The block round-robin arbitrates, computes the ROM address, drives the ROM read and returns the reward tagged to the winning requester.
- Sits between the per-agent update pipelines and the reward ROM instance. Throughput is one lookup per cycle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- STATE_W, 6, state index width.
- ACTION_W, 2, action index width.
- NUM_ACTIONS, 4, legal actions per state.
- ADDR_WIDTH, 8, ROM address width.
- DATA_WIDTH, 8, reward width.
- DEPTH, 256, ROM entries.
- DEFAULT_REWARD, 8'hF7, reward returned for out-of-range lookups.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_hold  in  1  blocks new grants; in-flight lookups still complete.
- i_req  in  NUM_REQ  per-requester request. Held high until granted.
- i_state  in  NUM_REQ*STATE_W  packed states; requester k occupies slice k.
- i_action  in  NUM_REQ*ACTION_W  packed actions; requester k occupies slice k.
- o_gnt  out  NUM_REQ  one-hot grant, combinational in the cycle the request is accepted.
- o_rom_addr  out  ADDR_WIDTH  registered ROM address.
- o_rom_read  out  1  registered ROM read strobe.
- i_rom_data  in  DATA_WIDTH  ROM output, valid the cycle after o_rom_addr.
- o_rsp_valid  out  NUM_REQ  one-hot response valid; no backpressure.
- o_rsp_data  out  DATA_WIDTH  reward, shared across requesters.
- o_rsp_oor  out  1  the response was out-of-range and carries DEFAULT_REWARD.
- o_busy  out  1  at least one lookup is in flight.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low. All state clears immediately on assertion.
- Reset values: o_rom_addr=0, o_rom_read=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_oor=0, o_busy=0, round-robin pointer=0. o_gnt=0 while in reset.
- Reset mid-operation: in-flight lookups are discarded and no response is produced.
- Arbitration (cycle T):
  - If i_hold=0 and any i_req bit is set, grant the first set bit searching from the pointer upward, with wrap.
  - At most one o_gnt bit is set, and only where i_req is also set.
  - After a grant to k, the pointer becomes (k+1) mod NUM_REQ. With no grant, the pointer is unchanged.
  - A requester drops or changes its request only after seeing o_gnt.
- Address: idx = state*NUM_ACTIONS + action, computed at full width (STATE_W+ACTION_W+1 bits).
- Out-of-range: the lookup is out-of-range if action >= NUM_ACTIONS or idx >= DEPTH.
- Stage 1 (edge ending T):
  - In range: o_rom_addr <= idx[ADDR_WIDTH-1:0] and o_rom_read <= 1.
  - Out-of-range: o_rom_read <= 0 and o_rom_addr holds its previous value.
  - The tag is registered: one-hot requester id plus oor flag.
- Stage 2: the ROM registers the address at the edge ending T+1, so i_rom_data is valid in cycle T+2. The tag advances one stage.
- Response (cycle T+2):
  - o_rsp_valid = stage-2 tag, combinational from the tag register.
  - o_rsp_data = DEFAULT_REWARD if oor, else i_rom_data.
  - o_rsp_oor = oor flag.
  - Outside valid cycles, o_rsp_data and o_rsp_oor are 0.
- Latency: exactly 2 cycles from grant to response.
- Pipelining: back-to-back grants produce back-to-back responses in grant order.
- o_busy: OR of the stage-1 and stage-2 valid bits.
- i_hold: takes effect in the same cycle (o_gnt=0) and does not flush the pipeline. Deasserting it resumes arbitration from the stored pointer.
- Requests with a single requester: that requester is granted every cycle it requests.

Decomposition:
- Shared package rtable_pkg:
  - Reward-table constants: NUM_ACTIONS, DEPTH, DEFAULT_REWARD.
  - Widths: ADDR_WIDTH, DATA_WIDTH.
  - Typedef for the pipeline tag (one-hot id, oor).
- Sub-module rr_arbiter: combinational priority search from the pointer, plus the pointer register. It is reusable for the Q-table port arbiter.
- rtable_arbiter instantiates rr_arbiter, the address/range logic and the two tag pipeline stages.

Test Plan:
- Reset then single request: req0, state=3, action=2 → o_gnt=0001 in T. o_rom_addr=14, o_rom_read=1 in T+1. With ROM model returning 8'h05: o_rsp_valid=0001, o_rsp_data=8'h05, o_rsp_oor=0 in T+2.
- All four requesters held high for 8 cycles → grants 0,1,2,3,0,1,2,3 on consecutive cycles. Responses arrive in the same order 2 cycles later. o_busy stays high until 2 cycles after the last grant.
- Out-of-range: NUM_ACTIONS=3, action=3 → granted, o_rom_read=0, response o_rsp_data=8'hF7, o_rsp_oor=1. Repeat with state=63, action=3, NUM_ACTIONS=4, DEPTH=200 (idx 255) → same response.
- i_hold asserted the cycle after a grant to req1 while req2 and req3 are pending → no grants during hold, and req1's response is still delivered. After release, req2 is granted first.
- Reset asserted in cycle T+1 of an in-flight lookup → outputs zero immediately, no response after release, pointer=0 (req0 wins the next contention against req3).
